// File: rtl/rhythm_pkg.sv
// ============================================================================
//  rhythm_pkg
//  Shared round-state encoding, key codes and a BCD digit-increment helper.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package rhythm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] KEY_START  = 8'h2C;
    localparam logic [7:0] KEY_STOP   = 8'h01;
    localparam logic [7:0] KEY_LANE_A = 8'h04;

    // Returns {carry_out, digit_out}; a digit of 9 (or an illegal code) rolls to 0.
    function automatic logic [4:0] bcd_digit_inc(input logic [3:0] digit, input logic cin);
        logic [4:0] res;
        if (!cin) begin
            res = {1'b0, digit};
        end else if (digit >= 4'd9) begin
            res = {1'b1, 4'd0};
        end else begin
            res = {1'b0, digit + 4'd1};
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_counter4.sv
// ============================================================================
//  bcd_counter4
//  Four-digit BCD up-counter: synchronous clear, enable-increment, holds at 9999.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_counter4
    import rhythm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] count
);

    localparam logic [15:0] BCD_MAX = 16'h9999;

    logic [15:0] count_next;
    logic [4:0]  carry;
    logic [4:0]  digit_res;

    // Ripple the +1 from the units digit upward.
    always_comb begin
        count_next = count;
        carry      = 5'b00001;
        digit_res  = 5'd0;
        for (int d = 0; d < 4; d++) begin
            digit_res              = bcd_digit_inc(count[4*d +: 4], carry[d]);
            count_next[4*d +: 4]   = digit_res[3:0];
            carry[d+1]             = digit_res[4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'h0000;
        end else if (clr) begin
            count <= 16'h0000;
        end else if (inc && (count != BCD_MAX)) begin
            count <= count_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/score_tally.sv
// ============================================================================
//  score_tally
//  Counts dropper hit edges into a saturating BCD score and runs the round FSM.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module score_tally
    import rhythm_pkg::*;
#(
    parameter int NUM_LANES    = 40,
    parameter int GAME_FRAMES  = 3600,
    parameter int FLASH_FRAMES = 6,
    parameter int PEND_W       = 8
) (
    input  logic                 frame_clk,
    input  logic                 Reset_n,
    input  logic [7:0]           keycode,
    input  logic [7:0]           keycode_second,
    input  logic [NUM_LANES-1:0] score_in,
    output logic [15:0]          score_bcd,
    output logic                 playing,
    output logic                 game_over,
    output logic [11:0]          frames_left,
    output logic                 hit_flash
);

    localparam int HIT_W   = $clog2(NUM_LANES + 1);
    localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);
    localparam int SUM_W   = ((PEND_W > HIT_W) ? PEND_W : HIT_W) + 1;

    localparam logic [PEND_W-1:0]  PEND_MAX   = {PEND_W{1'b1}};
    localparam logic [11:0]        FRAMES_INI = 12'(GAME_FRAMES);
    localparam logic [FLASH_W-1:0] FLASH_INI  = FLASH_W'(FLASH_FRAMES);

    state_t                 state;
    state_t                 state_next;
    logic [PEND_W-1:0]      pending;
    logic [PEND_W-1:0]      pending_next;
    logic [NUM_LANES-1:0]   prev_score;
    logic [11:0]            frame_cnt;
    logic [11:0]            frame_cnt_next;
    logic [FLASH_W-1:0]     flash_cnt;
    logic [FLASH_W-1:0]     flash_cnt_next;
    logic [HIT_W-1:0]       new_hits;
    logic [SUM_W-1:0]       pend_sum;
    logic                   start_key;
    logic                   stop_key;
    logic                   score_clr;
    logic                   score_inc;

    assign start_key = (keycode == KEY_START) || (keycode_second == KEY_START);
    assign stop_key  = (keycode == KEY_STOP)  || (keycode_second == KEY_STOP);

    // Rising edges of the level-held flags.
    always_comb begin
        new_hits = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            new_hits = new_hits + HIT_W'(score_in[i] & ~prev_score[i]);
        end
    end

    always_comb begin
        state_next     = state;
        pending_next   = pending;
        frame_cnt_next = frame_cnt;
        flash_cnt_next = (flash_cnt != '0) ? (flash_cnt - FLASH_W'(1)) : flash_cnt;
        pend_sum       = '0;
        score_clr      = 1'b0;
        score_inc      = 1'b0;

        unique case (state)
            IDLE: begin
                if (start_key) begin
                    state_next     = PLAY;
                    score_clr      = 1'b1;
                    pending_next   = '0;
                    flash_cnt_next = '0;
                    frame_cnt_next = FRAMES_INI;
                end
            end
            PLAY: begin
                // One pending hit drains into the score per frame.
                score_inc    = (pending != '0);
                pend_sum     = SUM_W'(pending) + SUM_W'(new_hits) - SUM_W'(score_inc);
                pending_next = (pend_sum > SUM_W'(PEND_MAX)) ? PEND_MAX : pend_sum[PEND_W-1:0];
                if (new_hits != '0) begin
                    flash_cnt_next = FLASH_INI;
                end
                frame_cnt_next = frame_cnt - 12'd1;
                if (stop_key) begin
                    state_next = IDLE;
                end else if (frame_cnt == 12'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                pending_next = '0;
                if (stop_key) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            pending    <= '0;
            prev_score <= '0;
            frame_cnt  <= '0;
            flash_cnt  <= '0;
        end else begin
            state      <= state_next;
            pending    <= pending_next;
            prev_score <= score_in;
            frame_cnt  <= frame_cnt_next;
            flash_cnt  <= flash_cnt_next;
        end
    end

    bcd_counter4 u_score (
        .clk   (frame_clk),
        .rst_n (Reset_n),
        .clr   (score_clr),
        .inc   (score_inc),
        .count (score_bcd)
    );

    assign playing     = (state == PLAY);
    assign game_over   = (state == DONE);
    assign frames_left = playing ? frame_cnt : 12'd0;
    assign hit_flash   = (flash_cnt != '0) && playing;

endmodule

`default_nettype wire

// File: tb/tb_score_tally.sv
// ============================================================================
//  tb_score_tally
//  Directed-sequence bench with random hit patterns against a decimal model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_score_tally;
    import rhythm_pkg::*;

    localparam int NL   = 40;
    localparam int GF   = 200;
    localparam int FF   = 6;
    localparam int PW   = 8;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    kc = 8'h00;
    logic [7:0]    kc2 = 8'h00;
    logic [NL-1:0] sin = '0;
    logic [15:0]   score_bcd;
    logic          playing;
    logic          game_over;
    logic [11:0]   frames_left;
    logic          hit_flash;

    logic          cnt_clr = 1'b0;
    logic          cnt_inc = 1'b0;
    logic [15:0]   cnt_q;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 playing, 2 round over; score kept as a plain integer.
    int            m_state;
    int            m_score;
    int            m_pending;
    int            m_frames;
    int            m_flash;
    logic [NL-1:0] m_prev;
    int            c_val;

    always #5 clk = ~clk;

    score_tally #(
        .NUM_LANES    (NL),
        .GAME_FRAMES  (GF),
        .FLASH_FRAMES (FF),
        .PEND_W       (PW)
    ) dut (
        .frame_clk      (clk),
        .Reset_n        (rst_n),
        .keycode        (kc),
        .keycode_second (kc2),
        .score_in       (sin),
        .score_bcd      (score_bcd),
        .playing        (playing),
        .game_over      (game_over),
        .frames_left    (frames_left),
        .hit_flash      (hit_flash)
    );

    bcd_counter4 u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (cnt_q)
    );

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_score   = 0;
        m_pending = 0;
        m_frames  = 0;
        m_flash   = 0;
        m_prev    = '0;
        c_val     = 0;
    endtask

    task automatic model_step();
        bit st;
        bit sp;
        int nh;
        int dec;
        st = (kc == 8'h2C) || (kc2 == 8'h2C);
        sp = (kc == 8'h01) || (kc2 == 8'h01);
        nh = $countones(sin & ~m_prev);
        case (m_state)
            0: begin
                if (st) begin
                    m_state = 1; m_score = 0; m_pending = 0; m_flash = 0; m_frames = GF;
                end else if (m_flash > 0) begin
                    m_flash--;
                end
            end
            1: begin
                dec = (m_pending != 0) ? 1 : 0;
                if (dec == 1 && m_score < 9999) m_score++;
                m_pending = m_pending + nh - dec;
                if (m_pending > PMAX) m_pending = PMAX;
                if (nh != 0) m_flash = FF;
                else if (m_flash > 0) m_flash--;
                if (sp) m_state = 0;
                else if (m_frames == 1) m_state = 2;
                m_frames--;
            end
            default: begin
                m_pending = 0;
                if (m_flash > 0) m_flash--;
                if (sp) m_state = 0;
            end
        endcase
        m_prev = sin;
        if (cnt_clr) c_val = 0;
        else if (cnt_inc && c_val < 9999) c_val++;
    endtask

    task automatic check_all();
        chk("score_bcd", score_bcd, to_bcd(m_score));
        chk("playing", playing, (m_state == 1));
        chk("game_over", game_over, (m_state == 2));
        chk("frames_left", frames_left, (m_state == 1) ? m_frames : 0);
        chk("hit_flash", hit_flash, (m_flash != 0) && (m_state == 1));
        chk("pending", dut.pending, m_pending);
        chk("bcd_counter4", cnt_q, to_bcd(c_val));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    function automatic logic [NL-1:0] rand_flags();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[NL-1:0];
    endfunction

    initial begin
        int flash_n;
        int bound;
        bit seen_carry;

        // Reset state.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Idle with non-start keys and random flags: nothing happens.
        for (int i = 0; i < 4; i++) begin
            kc  = 8'($urandom_range(2, 43));
            kc2 = 8'($urandom_range(2, 43));
            sin = rand_flags();
            tick();
        end

        // Start, then a single held hit on lane 3.
        kc = 8'h2C; kc2 = 8'h00; sin = '0;
        tick();
        chk("start_playing", playing, 1'b1);
        kc = 8'h00;
        tick();
        sin[3] = 1'b1;
        tick();
        flash_n = hit_flash ? 1 : 0;
        tick();
        chk("single_hit_latency", score_bcd, 16'h0001);
        if (hit_flash) flash_n++;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (hit_flash) flash_n++;
        end
        chk("flash_length", flash_n, FF);
        chk("held_not_recounted", score_bcd, 16'h0001);

        // Five simultaneous edges drain one per frame.
        sin = sin | (40'h1F << 10);
        tick();
        repeat (6) tick();
        chk("simultaneous_score", score_bcd, 16'h0006);
        chk("simultaneous_pending", dut.pending, 0);

        // Heavy random hits until the round times out; crosses 0099 -> 0100.
        seen_carry = 1'b0;
        bound = 0;
        while (m_state == 1 && bound < 300) begin
            kc  = 8'($urandom_range(2, 43));
            kc2 = 8'($urandom_range(2, 43));
            sin = rand_flags();
            tick();
            if (m_score == 100 && !seen_carry) begin
                seen_carry = 1'b1;
                chk("carry_0100", score_bcd, 16'h0100);
            end
            bound++;
        end
        chk("carry_reached", seen_carry, 1'b1);
        chk("timeout_game_over", game_over, 1'b1);
        chk("timeout_frames_left", frames_left, 12'd0);

        // Hit edge and start key in DONE are ignored; secondary stop returns to IDLE.
        sin = ~sin; kc = 8'h2C;
        tick();
        tick();
        chk("done_ignores_start", game_over, 1'b1);
        kc = 8'h00; kc2 = 8'h01;
        tick();
        chk("done_to_idle", game_over, 1'b0);
        kc2 = 8'h00;
        tick();

        // Flags already high at start are never counted.
        sin = '1;
        tick();
        kc = 8'h2C;
        tick();
        kc = 8'h00;
        repeat (5) tick();
        chk("stale_flags", score_bcd, 16'h0000);
        sin[0] = 1'b0;
        tick();
        sin[0] = 1'b1;
        tick();
        tick();
        kc = 8'h01;
        tick();
        chk("stop_to_idle", playing, 1'b0);
        kc = 8'h00;
        tick();
        chk("stop_holds_score", score_bcd, 16'h0001);

        // Mid-round asynchronous reset at score 0042.
        kc = 8'h2C;
        tick();
        kc = 8'h00;
        bound = 0;
        while (m_score < 42 && bound < 150) begin
            sin = rand_flags();
            tick();
            bound++;
        end
        chk("preload_0042", score_bcd, 16'h0042);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            kc  = 8'($urandom_range(2, 43));
            sin = rand_flags();
            tick();
        end
        chk("reset_stays_idle", playing, 1'b0);
        kc = 8'h00;

        // Counter carry chain and saturation at 9999.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        bound = 0;
        while (c_val < 9999 && bound < 20000) begin
            cnt_inc = ($urandom_range(0, 3) != 0);
            tick();
            bound++;
        end
        cnt_inc = 1'b1;
        repeat (3) tick();
        chk("counter_saturate", cnt_q, 16'h9999);
        cnt_inc = 1'b0;
        cnt_clr = 1'b1;
        tick();
        chk("counter_clear", cnt_q, 16'h0000);
        cnt_clr = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
